irq_slot_router: RTL and testbench
==================================

Name: irq_slot_router

Overview:
Interrupt front-end directly upstream of the Dock address decoder. Synchronises per-slot active-low IRQ lines, masks and arbitrates them, and drives the host /INT line. Latches the winning slot and detects the Mode-2 vector acknowledge cycle. It supplies irq_int_active, irq_int_slot and irq_vec_cycle to the decoder, which steers /CS to the interrupting slot during the vector read.

Parameters:
- NUM_SLOTS, 5, number of tile slots / IRQ inputs (1..8).
- SLOT_IDX_WIDTH, (NUM_SLOTS<=1)?1:$clog2(NUM_SLOTS), width of the slot index.
- SYNC_STAGES, 2, flip-flop synchroniser depth per IRQ input (>=2).

Ports:
- clk  in  1  system clock; single clock domain, config port included.
- rst  in  1  synchronous reset, active-high.
- irq_n  in  NUM_SLOTS  async per-slot interrupt requests, level, active-low.
- m1_n  in  1  host M1, active-low.
- iorq_n  in  1  host /IORQ, active-low.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  8  config register address.
- cfg_wdata  in  8  config write data.
- cfg_rdata  out  8  config readback, combinational from cfg_addr.
- int_n  out  1  host /INT, active-low, registered.
- irq_int_active  out  1  latched interrupt is outstanding.
- irq_int_slot  out  SLOT_IDX_WIDTH  index of the latched slot.
- irq_vec_cycle  out  1  current cycle is the Mode-2 vector read.
- irq_pending  out  NUM_SLOTS  synchronised, masked request vector.

Behaviour:
- Reset values:
  - int_n=1, irq_int_active=0, irq_int_slot=0, irq_vec_cycle=0, irq_pending=0.
  - MASK=0, MODE=0, rr_ptr=0, all sync flops=0 (request inactive), state IDLE.
- Config registers (decoded when cfg_we=1):
  - 0x40 MASK: bit i=1 enables slot i; bits >= NUM_SLOTS ignored, read 0.
  - 0x41 MODE: bit0 0=fixed priority (lowest index wins), 1=round-robin starting at rr_ptr; other bits read 0.
  - 0x42 PEND: read-only, irq_pending zero-extended; writes ignored.
  - Unmapped addresses read 0x00.
- Request path:
  - req[i] = sync(~irq_n[i]) & MASK[i]; irq_pending = req.
  - Synchroniser latency is SYNC_STAGES edges.
- Arbiter:
  - Combinational pick over req.
  - Round-robin searches rr_ptr, rr_ptr+1, …, wrapping modulo NUM_SLOTS.
- FSM states and transitions:
  - IDLE: if any req, latch slot=pick, go to ASSERT. int_n=0 and irq_int_active=1 are registered on that same edge.
  - ASSERT: if m1_n=0 and iorq_n=0, go to ACK. Otherwise, if req[slot]=0 (source withdrew or was masked), retract: int_n=1, active=0, go to IDLE. Slot is never re-picked while in ASSERT.
  - ACK: irq_vec_cycle=1. When iorq_n=1, go to DONE; int_n=1 and irq_vec_cycle=0 on that edge. Retraction is ignored in ACK.
  - DONE: one holdoff cycle. active=0; rr_ptr=(slot+1) mod NUM_SLOTS when MODE=1. Go to IDLE. A still-asserted level source re-arbitrates on the next IDLE cycle.
- irq_vec_cycle is registered and asserted only in ACK. The decoder sees it 1 cycle after IORQ/M1 fall; the host's IORQ-to-data wait states absorb this.
- Latency: irq_n low sampled at edge N gives int_n low after edge N+SYNC_STAGES+1 (N+3 at default).
- Simultaneous events:
  - A cfg MASK write and arbitration on the same edge: arbitration uses the old MASK.
  - A cfg write while in ACK does not abort the ACK.
- iorq_n=0 with m1_n=1 is an ordinary I/O cycle; no state change in any state.
- rst asserted in any state: all outputs and registers return to reset values on the next edge; int_n released.

Decomposition:
- Package irq_slot_router_pkg holds:
  - state enum {IDLE, ASSERT, ACK, DONE};
  - localparams CFG_MASK=8'h40, CFG_MODE=8'h41, CFG_PEND=8'h42.
- One sub-module: irq_slot_arbiter. Combinational fixed/round-robin picker; inputs req, rr_ptr, mode; outputs any, idx.

Test Plan:
1. Reset, MASK=0x1F, MODE=0; drive irq_n[3]=0 → int_n=0 exactly 3 clk later, irq_int_slot=3, irq_int_active=1, irq_pending=0x08.
2. irq_n[1] and irq_n[4] low together, MODE=0 → slot=1. Then ACK (m1_n=0, iorq_n=0, then iorq_n=1), irq_n[1] released → second INT with slot=4 after DONE and 1 IDLE.
3. MODE=1, slots 0 and 2 held low continuously, run 4 ACK cycles → slot sequence 0,2,0,2; irq_vec_cycle=1 only during each ACK.
4. irq_n[2] low until int_n=0, then released before ACK → int_n returns to 1 one cycle after the synchronised release, active=0, no irq_vec_cycle pulse.
5. Write MASK=0x00 while in ASSERT for slot 0 → retraction to IDLE. Write MASK during ACK → ACK completes normally, irq_vec_cycle held until iorq_n=1.
6. rst=1 for 1 clk mid-ACK → int_n=1, irq_vec_cycle=0, MASK reads back 0x00 on cfg_rdata at address 0x40.

Source files
------------

// File: rtl/irq_slot_router_pkg.sv
// rtl/irq_slot_router_pkg.sv - shared types and config register map for the IRQ slot router
package irq_slot_router_pkg;

    // Interrupt handshake states: waiting, /INT driven, vector read in progress, holdoff.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        ACK    = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [7:0] CFG_MASK = 8'h40;
    localparam logic [7:0] CFG_MODE = 8'h41;
    localparam logic [7:0] CFG_PEND = 8'h42;

endpackage

// File: rtl/irq_slot_arbiter.sv
// rtl/irq_slot_arbiter.sv - combinational fixed-priority / round-robin slot picker
//
// Ports:
//   req    : masked, synchronised request vector
//   rr_ptr : first slot searched in round-robin mode
//   mode   : 0 = lowest index wins, 1 = round-robin from rr_ptr
//   any    : at least one request is set
//   idx    : index of the winning slot (0 when any=0)
module irq_slot_arbiter
    import irq_slot_router_pkg::*;
#(
    parameter int NUM_SLOTS      = 5,
    parameter int SLOT_IDX_WIDTH = (NUM_SLOTS <= 1) ? 1 : $clog2(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0]      req,
    input  logic [SLOT_IDX_WIDTH-1:0] rr_ptr,
    input  logic                      mode,
    output logic                      any,
    output logic [SLOT_IDX_WIDTH-1:0] idx
);

    localparam logic [SLOT_IDX_WIDTH-1:0] LAST_IDX = SLOT_IDX_WIDTH'(NUM_SLOTS - 1);

    logic [SLOT_IDX_WIDTH-1:0] pos;
    logic                      found;

    // Walk all slots once starting at the search origin; the first set request wins.
    // The position wraps at NUM_SLOTS rather than at the power of two.
    always_comb begin
        any   = |req;
        idx   = '0;
        found = 1'b0;
        pos   = mode ? rr_ptr : '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
            pos = (pos == LAST_IDX) ? '0 : pos + 1'b1;
        end
    end

endmodule

// File: rtl/irq_slot_router.sv
// rtl/irq_slot_router.sv - per-slot IRQ synchroniser, mask, arbiter and Mode-2 /INT handshake
//
// Ports:
//   clk, rst        : single clock, synchronous active-high reset
//   irq_n           : asynchronous active-low level requests, one per slot
//   m1_n, iorq_n    : host bus cycle qualifiers; both low = interrupt acknowledge
//   cfg_we/addr/wdata/rdata : config port (MASK 0x40, MODE 0x41, PEND 0x42 read-only)
//   int_n           : registered host /INT
//   irq_int_active  : an interrupt is latched and outstanding
//   irq_int_slot    : latched winning slot
//   irq_vec_cycle   : registered, high for the duration of the vector read
//   irq_pending     : synchronised, masked request vector
module irq_slot_router
    import irq_slot_router_pkg::*;
#(
    parameter int NUM_SLOTS      = 5,
    parameter int SLOT_IDX_WIDTH = (NUM_SLOTS <= 1) ? 1 : $clog2(NUM_SLOTS),
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SLOTS-1:0]      irq_n,
    input  logic                      m1_n,
    input  logic                      iorq_n,
    input  logic                      cfg_we,
    input  logic [7:0]                cfg_addr,
    input  logic [7:0]                cfg_wdata,
    output logic [7:0]                cfg_rdata,
    output logic                      int_n,
    output logic                      irq_int_active,
    output logic [SLOT_IDX_WIDTH-1:0] irq_int_slot,
    output logic                      irq_vec_cycle,
    output logic [NUM_SLOTS-1:0]      irq_pending
);

    localparam logic [SLOT_IDX_WIDTH-1:0] LAST_IDX = SLOT_IDX_WIDTH'(NUM_SLOTS - 1);

    logic [SYNC_STAGES-1:0][NUM_SLOTS-1:0] sync_q, sync_d;
    logic [NUM_SLOTS-1:0]      mask_q, mask_d;
    logic [NUM_SLOTS-1:0]      pend_q, pend_d;
    logic                      mode_q, mode_d;
    logic [SLOT_IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [SLOT_IDX_WIDTH-1:0] slot_q, slot_d;
    state_e                    state_q, state_d;
    logic                      int_n_q, int_n_d;
    logic                      active_q, active_d;
    logic                      vec_q, vec_d;

    logic                      arb_any;
    logic [SLOT_IDX_WIDTH-1:0] arb_idx;
    logic                      intack;
    logic                      cfg_unused;

    // Upper write-data bits have no storage behind them.
    assign cfg_unused = ^cfg_wdata;

    assign intack = !m1_n && !iorq_n;

    irq_slot_arbiter #(
        .NUM_SLOTS      (NUM_SLOTS),
        .SLOT_IDX_WIDTH (SLOT_IDX_WIDTH)
    ) u_arb (
        .req    (pend_q),
        .rr_ptr (rr_ptr_q),
        .mode   (mode_q),
        .any    (arb_any),
        .idx    (arb_idx)
    );

    // Request pipeline: SYNC_STAGES synchroniser flops on the inverted line, then one
    // registered mask stage. Arbitration always sees the mask as it was a cycle ago,
    // so a MASK write never races the pick made on the same edge.
    always_comb begin
        if (SYNC_STAGES > 1) begin
            sync_d = {sync_q[SYNC_STAGES-2:0], ~irq_n};
        end else begin
            sync_d = ~irq_n;
        end
        pend_d = sync_q[SYNC_STAGES-1] & mask_q;
    end

    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        if (cfg_we && cfg_addr == CFG_MASK) begin
            mask_d = cfg_wdata[NUM_SLOTS-1:0];
        end
        if (cfg_we && cfg_addr == CFG_MODE) begin
            mode_d = cfg_wdata[0];
        end
    end

    always_comb begin
        cfg_rdata = 8'h00;
        case (cfg_addr)
            CFG_MASK: cfg_rdata[NUM_SLOTS-1:0] = mask_q;
            CFG_MODE: cfg_rdata[0]             = mode_q;
            CFG_PEND: cfg_rdata[NUM_SLOTS-1:0] = pend_q;
            default:  ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        rr_ptr_d = rr_ptr_q;
        int_n_d  = int_n_q;
        active_d = active_q;
        vec_d    = vec_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    slot_d   = arb_idx;
                    int_n_d  = 1'b0;
                    active_d = 1'b1;
                    state_d  = ASSERT;
                end
            end
            ASSERT: begin
                // Acknowledge takes precedence over a withdrawal seen on the same edge.
                if (intack) begin
                    vec_d   = 1'b1;
                    state_d = ACK;
                end else if (!pend_q[slot_q]) begin
                    int_n_d  = 1'b1;
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            ACK: begin
                if (iorq_n) begin
                    int_n_d = 1'b1;
                    vec_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                active_d = 1'b0;
                if (mode_q) begin
                    rr_ptr_d = (slot_q == LAST_IDX) ? '0 : slot_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            mode_q   <= 1'b0;
            rr_ptr_q <= '0;
            slot_q   <= '0;
            state_q  <= IDLE;
            int_n_q  <= 1'b1;
            active_q <= 1'b0;
            vec_q    <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            rr_ptr_q <= rr_ptr_d;
            slot_q   <= slot_d;
            state_q  <= state_d;
            int_n_q  <= int_n_d;
            active_q <= active_d;
            vec_q    <= vec_d;
        end
    end

    assign int_n          = int_n_q;
    assign irq_int_active = active_q;
    assign irq_int_slot   = slot_q;
    assign irq_vec_cycle  = vec_q;
    assign irq_pending    = pend_q;

endmodule

// File: tb/tb_irq_slot_router.sv
// tb/tb_irq_slot_router.sv - self-checking bench for irq_slot_router
module tb_irq_slot_router;

    localparam int N    = 5;
    localparam int W    = 3;
    localparam int SYNC = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq_n;
    logic         m1_n;
    logic         iorq_n;
    logic         cfg_we;
    logic [7:0]   cfg_addr;
    logic [7:0]   cfg_wdata;
    logic [7:0]   cfg_rdata;
    logic         int_n;
    logic         irq_int_active;
    logic [W-1:0] irq_int_slot;
    logic         irq_vec_cycle;
    logic [N-1:0] irq_pending;

    int n_vec = 0;
    int n_err = 0;

    irq_slot_router #(.NUM_SLOTS(N), .SLOT_IDX_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_n          (irq_n),
        .m1_n           (m1_n),
        .iorq_n         (iorq_n),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_rdata      (cfg_rdata),
        .int_n          (int_n),
        .irq_int_active (irq_int_active),
        .irq_int_slot   (irq_int_slot),
        .irq_vec_cycle  (irq_vec_cycle),
        .irq_pending    (irq_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference arbitration: scan slots in priority order using modular arithmetic.
    function automatic int ref_pick(input int pat, input int rr_mode, input int start);
        for (int k = 0; k < N; k++) begin
            int s;
            s = rr_mode != 0 ? (start + k) % N : k;
            if (((pat >> s) & 1) != 0) return s;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg_wr(input logic [7:0] addr, input logic [7:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic cfg_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        cfg_addr = addr;
        #1;
        chk(tag, {24'h0, cfg_rdata}, {24'h0, exp});
    endtask

    // Ticks until int_n falls; -1 when the bound expires.
    task automatic wait_int(output int n);
        n = 0;
        while (int_n && n < 20) begin
            tick();
            n++;
        end
        if (int_n) n = -1;
    endtask

    // Full acknowledge: vector read held for 'hold' cycles; 'rel' slots let go on entry.
    task automatic run_ack(input string tag, input int hold, input logic [N-1:0] rel);
        m1_n   = 1'b0;
        iorq_n = 1'b0;
        tick();
        chk({tag, "_vec_on"}, irq_vec_cycle, 1);
        irq_n = irq_n | rel;
        repeat (hold) tick();
        chk({tag, "_vec_hold"}, irq_vec_cycle, 1);
        chk({tag, "_int_hold"}, int_n, 0);
        iorq_n = 1'b1;
        m1_n   = 1'b1;
        tick();
        chk({tag, "_int_off"}, int_n, 1);
        chk({tag, "_vec_off"}, irq_vec_cycle, 0);
    endtask

    initial begin
        int n;
        int ptr;
        int mask;
        int mode;
        int pat;
        int exp_slot;
        logic vec_seen;

        rst       = 1'b1;
        irq_n     = '1;
        m1_n      = 1'b1;
        iorq_n    = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = 8'h00;
        cfg_wdata = 8'h00;
        tick();
        tick();

        // Reset state
        chk("rst_int_n", int_n, 1);
        chk("rst_active", irq_int_active, 0);
        chk("rst_slot", irq_int_slot, 0);
        chk("rst_vec", irq_vec_cycle, 0);
        chk("rst_pending", irq_pending, 0);
        cfg_chk("rst_mask", 8'h40, 8'h00);
        cfg_chk("rst_mode", 8'h41, 8'h00);
        rst = 1'b0;

        // Single source latency, slot 3
        cfg_wr(8'h40, 8'hFF);
        cfg_chk("mask_rd", 8'h40, 8'h1F);
        cfg_wr(8'h41, 8'hFE);
        cfg_chk("mode_rd0", 8'h41, 8'h00);
        irq_n[3] = 1'b0;
        wait_int(n);
        // irq_n is first sampled on the first tick; int_n follows SYNC+1 edges later.
        chk("t1_latency", n - 1, SYNC + 1);
        chk("t1_slot", irq_int_slot, 3);
        chk("t1_active", irq_int_active, 1);
        chk("t1_pending", irq_pending, 5'h08);
        cfg_chk("t1_pend_rd", 8'h42, 8'h08);
        cfg_chk("t1_unmapped", 8'h43, 8'h00);
        // Ordinary I/O cycle must not disturb the handshake
        iorq_n = 1'b0;
        tick();
        tick();
        chk("io_int", int_n, 0);
        chk("io_vec", irq_vec_cycle, 0);
        iorq_n = 1'b1;
        run_ack("t1", 2, '1);
        repeat (4) tick();

        // Fixed priority then re-arbitration of the remaining source
        irq_n = ~5'b10010;
        wait_int(n);
        chk("t2_slot_a", irq_int_slot, 1);
        run_ack("t2a", 3, 5'b00010);
        wait_int(n);
        chk("t2_rearb_delay", n, 2);
        chk("t2_slot_b", irq_int_slot, 4);
        run_ack("t2b", 3, '1);
        repeat (4) tick();

        // Round-robin with two held sources
        do_reset();
        cfg_wr(8'h40, 8'h1F);
        cfg_wr(8'h41, 8'h01);
        cfg_chk("mode_rd1", 8'h41, 8'h01);
        irq_n = ~5'b00101;
        for (int i = 0; i < 4; i++) begin
            wait_int(n);
            chk("t3_int", n < 0, 0);
            chk("t3_slot", irq_int_slot, (i % 2 == 0) ? 0 : 2);
            chk("t3_vec_idle", irq_vec_cycle, 0);
            run_ack("t3", 1, (i == 3) ? 5'h1F : 5'h00);
        end
        repeat (4) tick();

        // Withdrawal before acknowledge
        irq_n[2] = 1'b0;
        wait_int(n);
        chk("t4_slot", irq_int_slot, 2);
        irq_n[2] = 1'b1;
        n = 0;
        vec_seen = 1'b0;
        while (!int_n && n < 20) begin
            tick();
            n++;
            vec_seen = vec_seen | irq_vec_cycle;
        end
        chk("t4_release_delay", n, SYNC + 2);
        chk("t4_active", irq_int_active, 0);
        chk("t4_no_vec", vec_seen, 0);

        // Mask removed while asserted, then mask write inside an acknowledge
        cfg_wr(8'h41, 8'h00);
        irq_n[0] = 1'b0;
        wait_int(n);
        chk("t5_slot", irq_int_slot, 0);
        cfg_wr(8'h40, 8'h00);
        n = 0;
        while (!int_n && n < 10) begin
            tick();
            n++;
        end
        chk("t5_retract", int_n, 1);
        chk("t5_active", irq_int_active, 0);
        cfg_wr(8'h40, 8'h1F);
        wait_int(n);
        chk("t5_reassert", n < 0, 0);
        m1_n   = 1'b0;
        iorq_n = 1'b0;
        tick();
        cfg_wr(8'h40, 8'h00);
        tick();
        tick();
        chk("t5_ack_vec", irq_vec_cycle, 1);
        chk("t5_ack_int", int_n, 0);
        iorq_n = 1'b1;
        m1_n   = 1'b1;
        tick();
        chk("t5_end_int", int_n, 1);
        chk("t5_end_vec", irq_vec_cycle, 0);
        irq_n = '1;
        repeat (4) tick();

        // Reset in the middle of an acknowledge
        cfg_wr(8'h40, 8'h1F);
        irq_n[1] = 1'b0;
        wait_int(n);
        m1_n   = 1'b0;
        iorq_n = 1'b0;
        tick();
        chk("t6_vec_pre", irq_vec_cycle, 1);
        do_reset();
        chk("t6_int", int_n, 1);
        chk("t6_vec", irq_vec_cycle, 0);
        chk("t6_active", irq_int_active, 0);
        cfg_chk("t6_mask", 8'h40, 8'h00);
        irq_n  = '1;
        m1_n   = 1'b1;
        iorq_n = 1'b1;
        repeat (4) tick();

        // Randomised arbitration against the reference picker
        do_reset();
        ptr = 0;
        for (int it = 0; it < 30; it++) begin
            mask = int'($urandom_range(1, 31));
            mode = int'($urandom_range(0, 1));
            cfg_wr(8'h40, 8'(mask));
            cfg_wr(8'h41, 8'(mode));
            cfg_chk("rnd_unmapped", 8'($urandom_range(0, 63)), 8'h00);
            pat = int'($urandom_range(1, 31));
            if ((pat & mask) == 0) pat = pat | (mask & (~mask + 1));
            irq_n = ~pat[N-1:0];
            wait_int(n);
            chk("rnd_int", n < 0, 0);
            exp_slot = ref_pick(pat & mask, mode, ptr);
            chk("rnd_slot", irq_int_slot, exp_slot);
            chk("rnd_pending", irq_pending, pat & mask);
            run_ack("rnd", int'($urandom_range(3, 5)), '1);
            if (mode != 0) ptr = (exp_slot + 1) % N;
            repeat (4) tick();
            chk("rnd_idle", int_n, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
